// File: rtl/reg_arb_pkg.sv
// ----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-bank write arbiter:
//   - arb_state_t : FSM state encoding (IDLE / BUSY)
//   - DEF_*       : default values for the arbiter parameters
//   - IDLE_CNT_W  : width of the owner-idle counter (covers TIMEOUT up to 255)
// ----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_TIMEOUT = 15;

    localparam int IDLE_CNT_W  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector. Returns the first asserted request
// found when scanning upward from index ptr and wrapping around to 0.
//
// Ports:
//   req       in  [N_REQ-1:0]  request vector
//   ptr       in  [PTR_W-1:0]  index holding highest priority
//   winner    out [PTR_W-1:0]  selected index (0 when nothing requests)
//   any_valid out              at least one request present
// ----------------------------------------------------------------------------
module rr_priority_pick
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_valid
);

    // Requests at or above ptr win over those that need a wrap-around.
    // Splitting the vector this way avoids modulo arithmetic for
    // non-power-of-two requester counts.
    logic [N_REQ-1:0] at_or_above;
    logic [N_REQ-1:0] upper_req;
    logic             upper_hit;
    logic [PTR_W-1:0] upper_idx;
    logic [PTR_W-1:0] lower_idx;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign at_or_above[gi] = (PTR_W'(gi) >= ptr);
        end
    endgenerate

    assign upper_req = req & at_or_above;

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        upper_hit = 1'b0;
        upper_idx = '0;
        lower_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                upper_idx = PTR_W'(i);
                upper_hit = 1'b1;
            end
            if (req[i]) begin
                lower_idx = PTR_W'(i);
            end
        end
    end

    assign winner    = upper_hit ? upper_idx : lower_idx;
    assign any_valid = |req;

endmodule

// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
// Grants one of N_REQ requesters exclusive ownership of a register bank for
// a whole burst. Ownership ends on an accepted beat flagged last, or when
// the owner presents no beat for TIMEOUT consecutive cycles. Accepted beats
// are forwarded to the bank through a one-cycle register stage.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [N_REQ]         beat valid per requester
//   req_last     in   [N_REQ]         last beat of burst per requester
//   req_addr     in   [N_REQ*ADDR_W]  address, requester i in slice i
//   req_data     in   [N_REQ*DATA_W]  data, requester i in slice i
//   req_ready    out  [N_REQ]         one-hot on the owner while BUSY, else 0
//   wr_en        out                  bank write strobe
//   wr_addr      out  [ADDR_W]        bank write address
//   wr_data      out  [DATA_W]        bank write data
//   busy         out                  a burst owns the bank
//   grant_id     out  [$clog2(N_REQ)] current or most recent owner
//   timeout_err  out                  one-cycle pulse on forced release
// ----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);

    // The counter value seen in the last tolerated idle cycle; reaching it
    // without a beat means this is the TIMEOUT-th idle cycle.
    localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]      LAST_IDX   = PTR_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t              state_reg,       state_next;
    logic [PTR_W-1:0]        ptr_reg,         ptr_next;
    logic [PTR_W-1:0]        grant_id_reg,    grant_id_next;
    logic [IDLE_CNT_W-1:0]   idle_cnt_reg,    idle_cnt_next;
    logic                    wr_en_reg,       wr_en_next;
    logic [ADDR_W-1:0]       wr_addr_reg,     wr_addr_next;
    logic [DATA_W-1:0]       wr_data_reg,     wr_data_next;
    logic                    timeout_err_reg, timeout_err_next;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  accept_vec;
    logic              accept;
    logic              accept_last;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [PTR_W-1:0]  grant_id_inc;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    // Owner one-hot doubles as req_ready: it is only non-zero while BUSY,
    // so IDLE automatically presents an all-zero ready vector.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
            assign owner_oh[gi] = (state_reg == ST_BUSY) &&
                                  (grant_id_reg == PTR_W'(gi));
        end
    endgenerate

    assign accept_vec  = owner_oh & req_valid;
    assign accept      = |accept_vec;
    assign accept_last = |(accept_vec & req_last);

    // AND-OR mux of the owner's address/data slices.
    always_comb begin
        beat_addr = '0;
        beat_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            beat_addr = beat_addr | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{owner_oh[i]}});
            beat_data = beat_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{owner_oh[i]}});
        end
    end

    // Pointer for the next arbitration: one past the releasing owner.
    assign grant_id_inc = (grant_id_reg == LAST_IDX) ? '0 : grant_id_reg + PTR_W'(1);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_id_next    = grant_id_reg;
        idle_cnt_next    = idle_cnt_reg;
        timeout_err_next = 1'b0;
        wr_en_next       = accept;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;

        if (accept) begin
            wr_addr_next = beat_addr;
            wr_data_next = beat_data;
        end

        case (state_reg)
            ST_IDLE: begin
                idle_cnt_next = '0;
                if (pick_any) begin
                    grant_id_next = pick_idx;
                    state_next    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (accept) begin
                    idle_cnt_next = '0;
                    if (accept_last) begin
                        state_next = ST_IDLE;
                        ptr_next   = grant_id_inc;
                    end
                end else if (idle_cnt_reg == IDLE_LIMIT) begin
                    // Owner went quiet too long: reclaim the bank and move
                    // priority past it so a stalled requester cannot starve others.
                    state_next       = ST_IDLE;
                    ptr_next         = grant_id_inc;
                    idle_cnt_next    = '0;
                    timeout_err_next = 1'b1;
                end else begin
                    idle_cnt_next = idle_cnt_reg + IDLE_CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            grant_id_reg    <= '0;
            idle_cnt_reg    <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_id_reg    <= grant_id_next;
            idle_cnt_reg    <= idle_cnt_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = owner_oh;
    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign busy        = (state_reg == ST_BUSY);
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 8, write data width.
REQ-003 Parameter ADDR_W, default 3, register-bank address width.
REQ-004 Parameter TIMEOUT, default 15, idle cycles tolerated from the burst owner before forced release (1..255).
REQ-005 Port clk input 1: single clock, all state updates on posedge.
REQ-006 Port rst_n input 1: reset, asynchronous, active-low.
REQ-007 Port req_valid input N_REQ: per-requester beat valid.
REQ-008 Port req_last input N_REQ: per-requester last beat of burst.
REQ-009 Port req_addr input N_REQ*ADDR_W: per-requester address, requester i in slice i.
REQ-010 Port req_data input N_REQ*DATA_W: per-requester data, requester i in slice i.
REQ-011 Port req_ready output N_REQ: one-hot or zero, beat accepted when valid&ready.
REQ-012 Port wr_en output 1: register-bank write strobe.
REQ-013 Port wr_addr output ADDR_W: register-bank write address.
REQ-014 Port wr_data output DATA_W: register-bank write data.
REQ-015 Port busy output 1: high while a burst owns the bank.
REQ-016 Port grant_id output $clog2(N_REQ): index of current or last owner.
REQ-017 Port timeout_err output 1: one-cycle pulse on forced release.

Function
REQ-018 FSM SHALL have states IDLE and BUSY.
REQ-019 In IDLE, req_ready SHALL be all-zero.
REQ-020 In IDLE with any req_valid high, the block SHALL pick the winner round-robin, starting at index ptr, register grant_id, and enter BUSY next cycle.
REQ-021 In BUSY, req_ready SHALL equal one-hot(grant_id); all other requesters SHALL see ready low.
REQ-022 Each accepted beat SHALL appear on wr_en/wr_addr/wr_data exactly one cycle later (registered, latency 1).
REQ-023 wr_en SHALL be low in every cycle following a cycle with no accepted beat.
REQ-024 An accepted beat with req_last high SHALL return the FSM to IDLE next cycle and set ptr = (grant_id+1) mod N_REQ.
REQ-025 An idle counter SHALL reset to 0 on every accepted beat and increment each BUSY cycle without one.
REQ-026 When the idle counter reaches TIMEOUT, the FSM SHALL enter IDLE next cycle, set ptr = (grant_id+1) mod N_REQ, and pulse timeout_err for one cycle.
REQ-027 Owner dropping req_valid mid-burst SHALL NOT release the grant before timeout.
REQ-028 Minimum gap between bursts SHALL be one IDLE cycle; back-to-back bursts from different requesters SHALL alternate fairly.
REQ-029 busy SHALL be high exactly when the FSM is in BUSY.

Reset
REQ-030 rst_n low SHALL immediately force: FSM IDLE, ptr 0, grant_id 0, idle counter 0, req_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, timeout_err 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; a beat in flight SHALL NOT be written.
REQ-032 After rst_n rises, requester 0 SHALL have highest priority.

Structure
REQ-033 Package reg_arb_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-034 Combinational round-robin selection SHALL be a sub-module rr_priority_pick (inputs: request vector, ptr; outputs: winner index, any-valid).

Verification
REQ-035 Reset then req_valid=0001, addr 5, data 0xA5, last=1 -> busy after 1 cycle, ready[0] next, wr_en with addr 5/data 0xA5 one cycle after acceptance, back to IDLE.
REQ-036 All four requesters valid with single-beat bursts -> grants in order 0,1,2,3,0; no requester granted twice before others.
REQ-037 Requester 2 burst of 3 beats (data 0x11,0x22,0x33) while 1 and 3 request -> 3 consecutive writes, ready only on bit 2, then grant to 3.
REQ-038 Owner drops valid for 15 cycles mid-burst -> timeout_err single pulse, IDLE, next grant goes to owner+1.
REQ-039 rst_n pulsed low during beat 2 of a burst -> all outputs 0 immediately, no write of beat 2, ptr back to 0.
